// File: rtl/mips_defs_pkg.sv
// mips_defs_pkg: opcode/funct codes, writeback select codes and register constants shared across stages.
package mips_defs_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LB = 6'h20,
                         OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25,
                         OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09, FN_MFHI = 6'h10, FN_MFLO = 6'h12,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23;
  localparam logic [2:0] WDS_AO = 3'd0, WDS_LOAD = 3'd1, WDS_PC8 = 3'd2, WDS_MD = 3'd3;
  localparam logic [4:0] REG_RA = 5'd31;
  typedef enum logic [1:0] {WA_RD, WA_RT, WA_RA} waddr_src_e;
  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction
endpackage

// File: rtl/wb_decode.sv
// wb_decode: combinational writeback decode of opcode/funct into writer flag, address source and data select.
module wb_decode
  import mips_defs_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [5:0]  fn_i,
  output logic        writer_o,
  output waddr_src_e  waddr_src_o,
  output logic [2:0]  wd_sel_o
);
  always_comb begin
    writer_o    = 1'b0;
    waddr_src_o = WA_RD;
    wd_sel_o    = WDS_AO;
    if (op_i == OP_RTYPE) begin
      writer_o = fn_i inside {FN_ADDU, FN_SUBU, FN_JALR, FN_MFHI, FN_MFLO};
      wd_sel_o = fn_i == FN_JALR ? WDS_PC8 : fn_i inside {FN_MFHI, FN_MFLO} ? WDS_MD : WDS_AO;
    end else begin
      writer_o    = is_load(op_i) || op_i inside {OP_ORI, OP_LUI, OP_ADDI, OP_JAL};
      waddr_src_o = op_i == OP_JAL ? WA_RA : WA_RT;
      wd_sel_o    = is_load(op_i) ? WDS_LOAD : op_i == OP_JAL ? WDS_PC8 : WDS_AO;
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with stall/flush, load extension and resolved GRF write port.
module mem_wb_stage
  import mips_defs_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          AW       = 5,
  parameter logic [DW-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          m_valid,
  input  logic [DW-1:0] m_instr,
  input  logic [DW-1:0] m_pc,
  input  logic [DW-1:0] m_rd,
  input  logic [DW-1:0] m_ao,
  input  logic [DW-1:0] m_md,
  output logic          w_valid,
  output logic [DW-1:0] w_instr,
  output logic [DW-1:0] w_pc,
  output logic          w_we,
  output logic [AW-1:0] w_waddr,
  output logic [DW-1:0] w_wd,
  output logic [2:0]    w_wd_sel
);
  logic          valid_q, valid_d;
  logic [DW-1:0] instr_q, instr_d, pc_q, pc_d, rd_q, rd_d, ao_q, ao_d, md_q, md_d;
  logic          writer;
  waddr_src_e    waddr_src;
  logic [5:0]    op;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [DW-1:0] load_v;
  logic          unused_fields;
  always_comb begin
    valid_d = flush ? 1'b0     : stall ? valid_q : m_valid;
    instr_d = flush ? '0       : stall ? instr_q : m_instr;
    pc_d    = flush ? RESET_PC : stall ? pc_q    : m_pc;
    rd_d    = flush ? '0       : stall ? rd_q    : m_rd;
    ao_d    = flush ? '0       : stall ? ao_q    : m_ao;
    md_d    = flush ? '0       : stall ? md_q    : m_md;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      ao_q    <= '0;
      md_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      ao_q    <= ao_d;
      md_q    <= md_d;
    end
  end
  assign op = instr_q[31:26];
  wb_decode u_dec (
    .op_i       (op),
    .fn_i       (instr_q[5:0]),
    .writer_o   (writer),
    .waddr_src_o(waddr_src),
    .wd_sel_o   (w_wd_sel)
  );
  // Halfword lane comes from ao[1] only; misaligned halves are trapped before this stage.
  assign byte_v = rd_q[{ao_q[1:0], 3'b000} +: 8];
  assign half_v = ao_q[1] ? rd_q[31:16] : rd_q[15:0];
  always_comb begin
    load_v = op == OP_LW  ? rd_q :
             op == OP_LB  ? {{(DW-8){byte_v[7]}}, byte_v} :
             op == OP_LBU ? {{(DW-8){1'b0}}, byte_v} :
             op == OP_LH  ? {{(DW-16){half_v[15]}}, half_v} :
                            {{(DW-16){1'b0}}, half_v};
    w_wd = w_wd_sel == WDS_LOAD ? load_v :
           w_wd_sel == WDS_PC8  ? pc_q + DW'(8) :
           w_wd_sel == WDS_MD   ? md_q : ao_q;
    w_waddr = waddr_src == WA_RA ? AW'(REG_RA) :
              waddr_src == WA_RT ? AW'(instr_q[20:16]) : AW'(instr_q[15:11]);
  end
  assign w_we          = valid_q & writer & (w_waddr != '0);
  assign w_valid       = valid_q;
  assign w_instr       = instr_q;
  assign w_pc          = pc_q;
  assign unused_fields = ^{instr_q[25:21], instr_q[10:6]};
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vector table plus stall/flush/reset sequences for mem_wb_stage.
module tb_mem_wb_stage;
  logic        clk = 1'b0, reset, stall, flush, m_valid;
  logic [31:0] m_instr, m_pc, m_rd, m_ao, m_md;
  logic        w_valid, w_we;
  logic [31:0] w_instr, w_pc, w_wd;
  logic [4:0]  w_waddr;
  logic [2:0]  w_wd_sel;
  int total = 0, bad = 0;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] instr, pc, rd, ao, md;
    logic        we;
    logic [4:0]  wa;
    logic        chk_wa;
    logic [31:0] wd;
    logic [2:0]  sel;
    logic        chk_wd;
  } vec_t;
  vec_t tv[$];

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_instr(m_instr), .m_pc(m_pc), .m_rd(m_rd), .m_ao(m_ao), .m_md(m_md),
    .w_valid(w_valid), .w_instr(w_instr), .w_pc(w_pc), .w_we(w_we),
    .w_waddr(w_waddr), .w_wd(w_wd), .w_wd_sel(w_wd_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, p, r, a, m);
    @(negedge clk);
    m_valid = v; m_instr = i; m_pc = p; m_rd = r; m_ao = a; m_md = m;
  endtask

  initial begin
    // name, v, instr, pc, rd, ao, md, we, wa, chk_wa, wd, sel, chk_wd
    tv.push_back('{"lb_ao1",   1, 32'h80080000, 32'h3000, 32'h8899AABB, 32'h1, 0, 1, 8, 1, 32'hFFFFFFAA, 1, 1});
    tv.push_back('{"lb_ao0",   1, 32'h80080000, 32'h3004, 32'h8899AABB, 32'h0, 0, 1, 8, 1, 32'hFFFFFFBB, 1, 1});
    tv.push_back('{"lb_ao2",   1, 32'h80080000, 32'h3008, 32'h8899AABB, 32'h2, 0, 1, 8, 1, 32'hFFFFFF99, 1, 1});
    tv.push_back('{"lbu_ao3",  1, 32'h90080000, 32'h300C, 32'h8899AABB, 32'h3, 0, 1, 8, 1, 32'h00000088, 1, 1});
    tv.push_back('{"lh_ao2",   1, 32'h84030000, 32'h3010, 32'h8899AABB, 32'h2, 0, 1, 3, 1, 32'hFFFF8899, 1, 1});
    tv.push_back('{"lh_ao3",   1, 32'h84030000, 32'h3014, 32'h8899AABB, 32'h3, 0, 1, 3, 1, 32'hFFFF8899, 1, 1});
    tv.push_back('{"lhu_ao0",  1, 32'h94030000, 32'h3018, 32'h8899AABB, 32'h0, 0, 1, 3, 1, 32'h0000AABB, 1, 1});
    tv.push_back('{"lw",       1, 32'h8C040000, 32'h301C, 32'hDEADBEEF, 32'h8, 0, 1, 4, 1, 32'hDEADBEEF, 1, 1});
    tv.push_back('{"jal",      1, 32'h0C000000, 32'h3010, 0, 32'h5, 0, 1, 31, 1, 32'h00003018, 2, 1});
    tv.push_back('{"jal_wrap", 1, 32'h0C000000, 32'hFFFFFFFC, 0, 0, 0, 1, 31, 1, 32'h00000004, 2, 1});
    tv.push_back('{"jalr",     1, 32'h00003809, 32'h00000100, 0, 0, 0, 1, 7, 1, 32'h00000108, 2, 1});
    tv.push_back('{"addu_r0",  1, 32'h00000021, 32'h3020, 0, 32'h55, 0, 0, 0, 1, 32'h00000055, 0, 1});
    tv.push_back('{"addu_r5",  1, 32'h00002821, 32'h3024, 0, 32'h7, 0, 1, 5, 1, 32'h00000007, 0, 1});
    tv.push_back('{"subu_r10", 1, 32'h00005023, 32'h3028, 0, 32'hFFFF0001, 0, 1, 10, 1, 32'hFFFF0001, 0, 1});
    tv.push_back('{"mfhi_r9",  1, 32'h00004810, 32'h302C, 0, 32'h1, 32'h12345678, 1, 9, 1, 32'h12345678, 3, 1});
    tv.push_back('{"mflo_r9",  1, 32'h00004812, 32'h3030, 0, 32'h1, 32'hCAFEF00D, 1, 9, 1, 32'hCAFEF00D, 3, 1});
    tv.push_back('{"ori_r1",   1, 32'h34010000, 32'h3034, 0, 32'h1234, 0, 1, 1, 1, 32'h00001234, 0, 1});
    tv.push_back('{"lui_r2",   1, 32'h3C020000, 32'h3038, 0, 32'hABCD0000, 0, 1, 2, 1, 32'hABCD0000, 0, 1});
    tv.push_back('{"addi_r6",  1, 32'h20060000, 32'h303C, 0, 32'h9, 0, 1, 6, 1, 32'h00000009, 0, 1});
    tv.push_back('{"sw",       1, 32'hAC080000, 32'h3040, 0, 32'h40, 0, 0, 0, 0, 32'h00000040, 0, 1});
    tv.push_back('{"unk_3f",   1, 32'hFC000000, 32'h3044, 0, 32'h44, 0, 0, 0, 0, 32'h00000044, 0, 1});
    tv.push_back('{"beq",      1, 32'h10000000, 32'h3048, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{"j",        1, 32'h08000000, 32'h304C, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{"jr",       1, 32'h03E00008, 32'h3050, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{"invalid",  0, 32'h00002821, 32'h3054, 0, 32'h7, 0, 0, 0, 0, 0, 0, 0});

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    m_valid = 1'b1; m_instr = 32'h00002821; m_pc = 32'h1234; m_rd = '1; m_ao = 32'h7; m_md = '1;
    step();
    step();
    chk("rst_valid", 32'(w_valid), 0);
    chk("rst_we", 32'(w_we), 0);
    chk("rst_pc", w_pc, 32'h3000);
    chk("rst_instr", w_instr, 0);
    chk("rst_waddr", 32'(w_waddr), 0);
    chk("rst_wd", w_wd, 0);
    chk("rst_sel", 32'(w_wd_sel), 0);
    @(negedge clk) reset = 1'b0;

    foreach (tv[k]) begin
      drive(tv[k].v, tv[k].instr, tv[k].pc, tv[k].rd, tv[k].ao, tv[k].md);
      step();
      chk({tv[k].name, "_valid"}, 32'(w_valid), 32'(tv[k].v));
      chk({tv[k].name, "_instr"}, w_instr, tv[k].instr);
      chk({tv[k].name, "_pc"}, w_pc, tv[k].pc);
      chk({tv[k].name, "_we"}, 32'(w_we), 32'(tv[k].we));
      if (tv[k].chk_wa) chk({tv[k].name, "_waddr"}, 32'(w_waddr), 32'(tv[k].wa));
      if (tv[k].chk_wd) begin
        chk({tv[k].name, "_wd"}, w_wd, tv[k].wd);
        chk({tv[k].name, "_sel"}, 32'(w_wd_sel), 32'(tv[k].sel));
      end
    end

    // Hold an ori through three stalled cycles while the MEM side keeps changing.
    drive(1, 32'h34010000, 32'h3020, 0, 32'h1234, 0);
    step();
    chk("ori_load_we", 32'(w_we), 1);
    chk("ori_load_wd", w_wd, 32'h1234);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stall = 1'b1;
      drive(1, 32'h00002821 + 32'(c << 11), 32'h4000 + 32'(c), 32'hFFFFFFFF, 32'h99 + 32'(c), 32'h5);
      step();
      chk("stall_instr", w_instr, 32'h34010000);
      chk("stall_pc", w_pc, 32'h3020);
      chk("stall_waddr", 32'(w_waddr), 1);
      chk("stall_wd", w_wd, 32'h1234);
      chk("stall_we", 32'(w_we), 1);
    end
    @(negedge clk) flush = 1'b1;
    step();
    chk("flush_valid", 32'(w_valid), 0);
    chk("flush_instr", w_instr, 0);
    chk("flush_we", 32'(w_we), 0);
    chk("flush_pc", w_pc, 32'h3000);

    // Reset must override an active stall.
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    drive(1, 32'h0C000000, 32'h3010, 0, 0, 0);
    step();
    chk("pre_rst_we", 32'(w_we), 1);
    @(negedge clk);
    stall = 1'b1; reset = 1'b1;
    step();
    chk("rst_stall_valid", 32'(w_valid), 0);
    chk("rst_stall_instr", w_instr, 0);
    chk("rst_stall_pc", w_pc, 32'h3000);
    chk("rst_stall_we", 32'(w_we), 0);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
